// File: rtl/adc_pkg.sv
// Shared definitions for the ADC serial capture path: FSM state encoding and
// default parameter values.
package adc_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_SHIFT    = 2'b01,
      S_DONE     = 2'b10,
      S_WAIT_LOW = 2'b11
   } adc_state_t;

   localparam int ADC_DATA_W_DEFAULT  = 8;
   localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises the asynchronous adc_dout pin and flags rising edges of the
// locally generated clk_adc.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clk_adc,
   input  logic adc_dout,
   output logic sync_bit,
   output logic adc_rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   clk_adc_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q    <= '0;
         clk_adc_d <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], adc_dout};
         clk_adc_d <= clk_adc;
      end
   end

   // clk_adc is already in the clk domain, so the edge is used the cycle it appears.
   assign adc_rise = clk_adc & ~clk_adc_d;
   assign sync_bit = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/adc_serial_capture.sv
// Serial-to-parallel capture of one ADC conversion word, MSB first, with
// end-of-conversion, valid/ack handshake, overrun and abort reporting.
module adc_serial_capture
   import adc_pkg::*;
#(
   parameter int DATA_W      = ADC_DATA_W_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_tx,
   input  logic              clk_adc,
   input  logic              adc_dout,
   input  logic              data_ack,
   output logic              eoc_signal,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              overrun,
   output logic              frame_abort
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   adc_state_t        state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              sync_bit;
   logic              adc_rise;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge_detect (
      .clk      (clk),
      .reset    (reset),
      .clk_adc  (clk_adc),
      .adc_dout (adc_dout),
      .sync_bit (sync_bit),
      .adc_rise (adc_rise)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         eoc_signal  <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         overrun     <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         eoc_signal  <= 1'b0;
         frame_abort <= 1'b0;

         // Completion sets valid even if the consumer acks in the same cycle.
         if (state == S_DONE)
            data_valid <= 1'b1;
         else if (data_ack)
            data_valid <= 1'b0;

         unique case (state)
            S_IDLE: begin
               bit_cnt <= '0;
               if (start_tx)
                  state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (!start_tx) begin
                  state       <= S_IDLE;
                  frame_abort <= 1'b1;
               end else if (adc_rise) begin
                  shreg   <= {shreg[DATA_W-2:0], sync_bit};
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(DATA_W - 1))
                     state <= S_DONE;
               end
            end
            S_DONE: begin
               eoc_signal <= 1'b1;
               data_out   <= shreg;
               if (data_valid && !data_ack)
                  overrun <= 1'b1;
               state <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               // Hold off re-arming until the clock generator has gone idle.
               if (!start_tx)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
- Serial-to-parallel capture stage for the external ADC, driven by the ADC clock/enable pair from the ADC clock generator.
- Detects rising edges of clk_adc and shifts in one synchronised adc_dout bit per edge, MSB first.
- After DATA_W bits, presents the parallel word and returns the one-cycle end-of-conversion pulse (eoc_signal) that stops the clock generator.
- Sits between the ADC pins and the downstream transmit/processing logic.

Parameters:
- DATA_W, 8: bits per conversion word; legal range 2..16.
- SYNC_STAGES, 2: flip-flop depth of the adc_dout synchroniser; legal range 2..3.

Ports:
- clk  input  1  system clock; the single clock domain.
- reset  input  1  synchronous, active-low reset.
- start_tx  input  1  frame enable from the clock generator; high for the whole conversion.
- clk_adc  input  1  ADC serial clock, generated in the clk domain.
- adc_dout  input  1  serial data from the ADC pin; asynchronous.
- data_ack  input  1  consumer has taken data_out; clears data_valid.
- eoc_signal  output  1  one-cycle end-of-conversion pulse.
- data_out  output  DATA_W  last completed conversion word.
- data_valid  output  1  data_out holds an unconsumed word.
- overrun  output  1  sticky: a word completed while data_valid was still set.
- frame_abort  output  1  one-cycle pulse when start_tx drops mid-frame.

Behaviour:
- Reset (reset==0 at a clk edge) forces all outputs, the shift register, bit counter, synchroniser and clk_adc_d to 0, and the state to S_IDLE. Reset mid-frame discards the partial word.
- adc_dout passes through SYNC_STAGES flops before use. The ADC must hold adc_dout stable at least SYNC_STAGES+1 clk cycles before each clk_adc rising edge.
- Edge detect: clk_adc_d is clk_adc registered. A rising edge is clk_adc & ~clk_adc_d, and is acted on in the same cycle it is detected.
- States:
  - S_IDLE: bit_cnt=0. If start_tx==1, go to S_SHIFT. A clk_adc edge coincident with that entry cycle is not sampled.
  - S_SHIFT:
    - If start_tx==0: go to S_IDLE, pulse frame_abort for 1 cycle, no eoc, data_out unchanged.
    - Else, on a rising edge: shreg <= {shreg[DATA_W-2:0], sync_bit}; bit_cnt++.
    - When the edge completes bit index DATA_W-1, go to S_DONE.
  - S_DONE (exactly 1 cycle): eoc_signal=1, data_out<=shreg, data_valid<=1. If data_valid was already 1 and data_ack==0 in this cycle, set overrun. Then go to S_WAIT_LOW.
  - S_WAIT_LOW: ignore clk_adc; stay until start_tx==0, then go to S_IDLE. This prevents re-arming before the generator has returned to idle.
- Latency: eoc_signal asserts 2 clk cycles after the final clk_adc rising edge (1 cycle edge-detect register, 1 cycle S_DONE register).
- data_valid: set in S_DONE; cleared on data_ack==1 when not in S_DONE. If S_DONE and data_ack coincide, set wins.
- overrun stays set until reset.
- eoc_signal, frame_abort and data_valid are registered outputs; no combinational path from any input to any output.
- bit_cnt width is clog2(DATA_W)+1 and never wraps within a frame.
- clk_adc edges in S_IDLE or S_WAIT_LOW are ignored.

Decomposition:
- Shared package adc_pkg holds:
  - the state encoding S_IDLE=2'b00, S_SHIFT=2'b01, S_DONE=2'b10, S_WAIT_LOW=2'b11;
  - ADC_DATA_W_DEFAULT=8;
  - SYNC_STAGES_DEFAULT=2.
- One natural sub-module: sync_edge_detect. It contains the adc_dout synchroniser and the clk_adc_d register, and outputs sync_bit and adc_rise. The FSM, shift register and output flags stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles while driving every input high -> all outputs 0; after release with start_tx=0, state stays S_IDLE.
- Nominal frame (DATA_W=8): start_tx=1, 8 clk_adc pulses of 4 cycles high / 4 low, adc_dout=8'hA5 MSB first -> eoc_signal is a single pulse 2 cycles after the 8th rising edge; data_out=8'hA5; data_valid=1.
- Handshake/overrun:
  - Complete a frame (8'h3C), then a second frame (8'hC3) without data_ack -> overrun=1, data_out=8'hC3.
  - Repeat with data_ack pulsed between the frames -> overrun=0.
  - Assert data_ack in the S_DONE cycle -> data_valid remains 1.
- Abort: drop start_tx after 5 edges -> frame_abort pulses once, no eoc_signal, data_out keeps its previous value. The next full frame with 8'h0F captures 8'h0F, with no stale bits.
- Wait-low: hold start_tx=1 for 10 cycles after eoc_signal while toggling clk_adc -> no further capture and no second eoc. Drop start_tx, raise it again -> a new frame captures correctly.
- Reset mid-frame: reset=0 after 3 edges -> all outputs 0, next frame (8'hFF) is clean.
